// File: rtl/falafel_header_lsu_if.sv
// falafel_header_lsu_if: request/response and memory port bundle for the header LSU.
// Signal suffixes (_i/_o) are from the LSU's point of view. The LSU connects through
// the slave modport; the allocator FSM plus memory side (or a bench) uses master.
interface falafel_header_lsu_if #(
  parameter int unsigned DATA_W = 64
) ();
  // Request from the allocator control FSM
  logic              req_val_i;
  logic              req_rdy_o;
  logic [2:0]        req_op_i;
  logic [DATA_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_size_i;
  logic [DATA_W-1:0] req_next_addr_i;
  logic [DATA_W-1:0] lock_ptr_i;
  logic [DATA_W-1:0] lock_id_i;
  // Response back to the allocator
  logic              rsp_val_o;
  logic              rsp_rdy_i;
  logic [DATA_W-1:0] rsp_addr_o;
  logic [DATA_W-1:0] rsp_size_o;
  logic [DATA_W-1:0] rsp_next_addr_o;
  logic              rsp_err_o;
  // Memory request channel
  logic              mem_req_val_o;
  logic              mem_req_rdy_i;
  logic              mem_req_we_o;
  logic              mem_req_cas_o;
  logic [DATA_W-1:0] mem_req_addr_o;
  logic [DATA_W-1:0] mem_req_wdata_o;
  logic [DATA_W-1:0] mem_req_cmp_o;
  // Memory response channel
  logic              mem_rsp_val_i;
  logic [DATA_W-1:0] mem_rsp_rdata_i;

  modport slave (
    input  req_val_i, req_op_i, req_addr_i, req_size_i, req_next_addr_i,
    input  lock_ptr_i, lock_id_i, rsp_rdy_i, mem_req_rdy_i, mem_rsp_val_i, mem_rsp_rdata_i,
    output req_rdy_o, rsp_val_o, rsp_addr_o, rsp_size_o, rsp_next_addr_o, rsp_err_o,
    output mem_req_val_o, mem_req_we_o, mem_req_cas_o, mem_req_addr_o, mem_req_wdata_o,
    output mem_req_cmp_o
  );

  modport master (
    output req_val_i, req_op_i, req_addr_i, req_size_i, req_next_addr_i,
    output lock_ptr_i, lock_id_i, rsp_rdy_i, mem_req_rdy_i, mem_rsp_val_i, mem_rsp_rdata_i,
    input  req_rdy_o, rsp_val_o, rsp_addr_o, rsp_size_o, rsp_next_addr_o, rsp_err_o,
    input  mem_req_val_o, mem_req_we_o, mem_req_cas_o, mem_req_addr_o, mem_req_wdata_o,
    input  mem_req_cmp_o
  );
endinterface

// File: rtl/falafel_header_lsu.sv
// falafel_header_lsu: executes allocator header operations (LOCK, UNLOCK, LOAD,
// EDIT_SIZE_AND_NEXT_ADDR, EDIT_NEXT_ADDR) over a single-word memory port, one at a time.
// Header = two words: size at addr, next_addr at addr + DATA_W/8 (wrapping).
// Optional feature macro: FALAFEL_LSU_LOCK_TIMEOUT_EN -- LOCK gives up with an error after
// LOCK_RETRY_MAX failed CAS attempts; without it LOCK retries forever.
module falafel_header_lsu #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned LOCK_RETRY_MAX = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  falafel_header_lsu_if.slave bus
);
  localparam logic [2:0] OpLock   = 3'd0;
  localparam logic [2:0] OpUnlock = 3'd1;
  localparam logic [2:0] OpLoad   = 3'd2;
  localparam logic [2:0] OpEditSn = 3'd3;
  localparam logic [2:0] OpEditN  = 3'd4;

  localparam logic [DATA_W-1:0] WordBytes = DATA_W'(DATA_W / 8);

  if ((DATA_W % 8) != 0 || DATA_W < 16 || LOCK_RETRY_MAX < 1) begin : g_bad_params
    $error("falafel_header_lsu: DATA_W must be a multiple of 8 >= 16, LOCK_RETRY_MAX >= 1");
  end

  typedef enum logic [1:0] {StIdle, StMemReq, StMemWait, StRsp} state_e;

  state_e            r_state, w_state_d;
  logic [2:0]        r_op, w_op_d;
  logic [DATA_W-1:0] r_addr, w_addr_d;
  logic [DATA_W-1:0] r_size, w_size_d;
  logic [DATA_W-1:0] r_next, w_next_d;
  logic [DATA_W-1:0] r_lock_ptr, w_lock_ptr_d;
  logic [DATA_W-1:0] r_lock_id, w_lock_id_d;
  logic              r_w, w_w_d;
  logic [DATA_W-1:0] r_rsp_addr, w_rsp_addr_d;
  logic [DATA_W-1:0] r_rsp_size, w_rsp_size_d;
  logic [DATA_W-1:0] r_rsp_next, w_rsp_next_d;
  logic              r_rsp_err, w_rsp_err_d;

`ifdef FALAFEL_LSU_LOCK_TIMEOUT_EN
  localparam int unsigned RetryW = $clog2(LOCK_RETRY_MAX + 1);
  logic [RetryW-1:0] r_retry, w_retry_d;
`endif

  logic [DATA_W-1:0] w_addr_hi;
  assign w_addr_hi = r_addr + WordBytes;  // wraps modulo 2^DATA_W

  // State and captured-request registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_op       <= '0;
      r_addr     <= '0;
      r_size     <= '0;
      r_next     <= '0;
      r_lock_ptr <= '0;
      r_lock_id  <= '0;
      r_w        <= 1'b0;
      r_rsp_addr <= '0;
      r_rsp_size <= '0;
      r_rsp_next <= '0;
      r_rsp_err  <= 1'b0;
`ifdef FALAFEL_LSU_LOCK_TIMEOUT_EN
      r_retry    <= '0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_op       <= w_op_d;
      r_addr     <= w_addr_d;
      r_size     <= w_size_d;
      r_next     <= w_next_d;
      r_lock_ptr <= w_lock_ptr_d;
      r_lock_id  <= w_lock_id_d;
      r_w        <= w_w_d;
      r_rsp_addr <= w_rsp_addr_d;
      r_rsp_size <= w_rsp_size_d;
      r_rsp_next <= w_rsp_next_d;
      r_rsp_err  <= w_rsp_err_d;
`ifdef FALAFEL_LSU_LOCK_TIMEOUT_EN
      r_retry    <= w_retry_d;
`endif
    end
  end

  // Next-state: request capture, word sequencing, CAS retry, response fill
  always_comb begin
    w_state_d    = r_state;
    w_op_d       = r_op;
    w_addr_d     = r_addr;
    w_size_d     = r_size;
    w_next_d     = r_next;
    w_lock_ptr_d = r_lock_ptr;
    w_lock_id_d  = r_lock_id;
    w_w_d        = r_w;
    w_rsp_addr_d = r_rsp_addr;
    w_rsp_size_d = r_rsp_size;
    w_rsp_next_d = r_rsp_next;
    w_rsp_err_d  = r_rsp_err;
`ifdef FALAFEL_LSU_LOCK_TIMEOUT_EN
    w_retry_d    = r_retry;
`endif

    case (r_state)
      StIdle: begin
        if (bus.req_val_i) begin
          w_op_d       = bus.req_op_i;
          w_addr_d     = bus.req_addr_i;
          w_size_d     = bus.req_size_i;
          w_next_d     = bus.req_next_addr_i;
          w_lock_ptr_d = bus.lock_ptr_i;
          w_lock_id_d  = bus.lock_id_i;
          w_w_d        = 1'b0;
          w_rsp_err_d  = 1'b0;
          w_state_d    = StMemReq;
`ifdef FALAFEL_LSU_LOCK_TIMEOUT_EN
          w_retry_d    = '0;
`endif
          // Preload the response with whatever the op echoes; reads fill the rest later
          case (bus.req_op_i)
            OpLock, OpUnlock: begin
              w_rsp_addr_d = bus.lock_ptr_i;
              w_rsp_size_d = '0;
              w_rsp_next_d = '0;
            end
            OpLoad: begin
              w_rsp_addr_d = bus.req_addr_i;
              w_rsp_size_d = '0;
              w_rsp_next_d = '0;
            end
            OpEditSn, OpEditN: begin
              w_rsp_addr_d = bus.req_addr_i;
              w_rsp_size_d = bus.req_size_i;
              w_rsp_next_d = bus.req_next_addr_i;
            end
            default: begin
              w_rsp_addr_d = bus.req_addr_i;
              w_rsp_size_d = bus.req_size_i;
              w_rsp_next_d = bus.req_next_addr_i;
              w_rsp_err_d  = 1'b1;
              w_state_d    = StRsp;
            end
          endcase
        end
      end

      StMemReq: begin
        if (bus.mem_req_rdy_i) begin
          w_state_d = StMemWait;
        end
      end

      StMemWait: begin
        if (bus.mem_rsp_val_i) begin
          case (r_op)
            OpLoad: begin
              if (!r_w) begin
                w_rsp_size_d = bus.mem_rsp_rdata_i;
                w_w_d        = 1'b1;
                w_state_d    = StMemReq;
              end else begin
                w_rsp_next_d = bus.mem_rsp_rdata_i;
                w_state_d    = StRsp;
              end
            end
            OpEditSn: begin
              if (!r_w) begin
                w_w_d     = 1'b1;
                w_state_d = StMemReq;
              end else begin
                w_state_d = StRsp;
              end
            end
            OpLock: begin
              w_rsp_next_d = bus.mem_rsp_rdata_i;
              if (bus.mem_rsp_rdata_i == '0) begin
                w_state_d = StRsp;
              end else begin
`ifdef FALAFEL_LSU_LOCK_TIMEOUT_EN
                if (r_retry == RetryW'(LOCK_RETRY_MAX - 1)) begin
                  w_rsp_err_d = 1'b1;
                  w_state_d   = StRsp;
                end else begin
                  w_retry_d = r_retry + RetryW'(1);
                  w_state_d = StMemReq;
                end
`else
                w_state_d = StMemReq;
`endif
              end
            end
            default: begin
              w_state_d = StRsp;
            end
          endcase
        end
      end

      StRsp: begin
        if (bus.rsp_rdy_i) begin
          w_state_d = StIdle;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Memory request fields, decoded from registered state so they hold steady while stalled
  always_comb begin
    bus.mem_req_val_o   = 1'b0;
    bus.mem_req_we_o    = 1'b0;
    bus.mem_req_cas_o   = 1'b0;
    bus.mem_req_addr_o  = '0;
    bus.mem_req_wdata_o = '0;
    bus.mem_req_cmp_o   = '0;  // compare value is always EMPTY_KEY (0)
    if (r_state == StMemReq) begin
      bus.mem_req_val_o = 1'b1;
      case (r_op)
        OpLock: begin
          bus.mem_req_cas_o   = 1'b1;
          bus.mem_req_addr_o  = r_lock_ptr;
          bus.mem_req_wdata_o = r_lock_id;
        end
        OpUnlock: begin
          bus.mem_req_we_o   = 1'b1;
          bus.mem_req_addr_o = r_lock_ptr;
        end
        OpLoad: begin
          bus.mem_req_addr_o = r_w ? w_addr_hi : r_addr;
        end
        OpEditSn: begin
          bus.mem_req_we_o    = 1'b1;
          bus.mem_req_addr_o  = r_w ? w_addr_hi : r_addr;
          bus.mem_req_wdata_o = r_w ? r_next : r_size;
        end
        default: begin
          bus.mem_req_we_o    = 1'b1;
          bus.mem_req_addr_o  = w_addr_hi;
          bus.mem_req_wdata_o = r_next;
        end
      endcase
    end
  end

  // Handshake and response outputs
  always_comb begin
    bus.req_rdy_o       = (r_state == StIdle);
    bus.rsp_val_o       = (r_state == StRsp);
    bus.rsp_addr_o      = r_rsp_addr;
    bus.rsp_size_o      = r_rsp_size;
    bus.rsp_next_addr_o = r_rsp_next;
    bus.rsp_err_o       = r_rsp_err;
  end
endmodule
